// File: rtl/load_data.sv
// Input-side loader for the in-place FFT: streams N samples into two banks by index parity.
// Define LOAD_DATA_BITREV_IN_EN to store samples in bit-reversed placement (DIT core).
module load_data #(
  parameter int N = 32,
  parameter int R = 5,
  parameter int D = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_LD_en,
  output logic         o_load_done,
  output logic         o_busy,
  input  logic         i_rx_valid,
  input  logic [D-1:0] i_rx_data,
  output logic         o_rx_ready,
  output logic         o_m0_w_en,
  output logic [R-2:0] o_m0_addr,
  output logic [D-1:0] o_m0_wdata,
  output logic         o_m1_w_en,
  output logic [R-2:0] o_m1_addr,
  output logic [D-1:0] o_m1_wdata
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE} state_t;

  state_t         r_ps, ps_d;
  logic [R-1:0]   r_cnt, cnt_d;
  logic [R-1:0]   idx;
  logic           accept;
  logic           rx_ready_d, load_done_d, busy_d;
  logic           m0_w_en_d, m1_w_en_d;
  logic [R-2:0]   m0_addr_d, m1_addr_d;
  logic [D-1:0]   m0_wdata_d, m1_wdata_d;

`ifdef LOAD_DATA_BITREV_IN_EN
  function automatic logic [R-1:0] bit_rev(input logic [R-1:0] v);
    logic [R-1:0] r;
    for (int i = 0; i < R; i++) r[i] = v[R-1-i];
    return r;
  endfunction

  assign idx = bit_rev(r_cnt);
`else
  assign idx = r_cnt;
`endif

  assign accept = (r_ps == ST_LOAD) && i_rx_valid && o_rx_ready;

  always_comb begin
    ps_d        = r_ps;
    cnt_d       = r_cnt;
    rx_ready_d  = o_rx_ready;
    load_done_d = 1'b0;
    m0_w_en_d   = 1'b0;
    m1_w_en_d   = 1'b0;
    m0_addr_d   = o_m0_addr;
    m1_addr_d   = o_m1_addr;
    m0_wdata_d  = o_m0_wdata;
    m1_wdata_d  = o_m1_wdata;

    unique case (r_ps)
      ST_IDLE: begin
        if (i_LD_en) begin
          ps_d       = ST_LOAD;
          rx_ready_d = 1'b1;
          cnt_d      = '0;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          // Bank is the parity of the whole index, not its LSB.
          if (^idx) begin
            m1_w_en_d  = 1'b1;
            m1_addr_d  = idx[R-2:0];
            m1_wdata_d = i_rx_data;
          end else begin
            m0_w_en_d  = 1'b1;
            m0_addr_d  = idx[R-2:0];
            m0_wdata_d = i_rx_data;
          end
          if (r_cnt == R'(N - 1)) begin
            cnt_d      = '0;
            rx_ready_d = 1'b0;
            ps_d       = ST_FLUSH;
          end else begin
            cnt_d = r_cnt + R'(1);
          end
        end
      end
      ST_FLUSH: begin
        load_done_d = 1'b1;
        ps_d        = ST_DONE;
      end
      ST_DONE: begin
        ps_d = ST_IDLE;
      end
      default: ps_d = ST_IDLE;
    endcase

    busy_d = (ps_d != ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ps        <= ST_IDLE;
      r_cnt       <= '0;
      o_rx_ready  <= 1'b0;
      o_load_done <= 1'b0;
      o_busy      <= 1'b0;
      o_m0_w_en   <= 1'b0;
      o_m0_addr   <= '0;
      o_m0_wdata  <= '0;
      o_m1_w_en   <= 1'b0;
      o_m1_addr   <= '0;
      o_m1_wdata  <= '0;
    end else begin
      r_ps        <= ps_d;
      r_cnt       <= cnt_d;
      o_rx_ready  <= rx_ready_d;
      o_load_done <= load_done_d;
      o_busy      <= busy_d;
      o_m0_w_en   <= m0_w_en_d;
      o_m0_addr   <= m0_addr_d;
      o_m0_wdata  <= m0_wdata_d;
      o_m1_w_en   <= m1_w_en_d;
      o_m1_addr   <= m1_addr_d;
      o_m1_wdata  <= m1_wdata_d;
    end
  end

endmodule

// File: tb/tb_load_data.sv
// Bench for load_data: full streams, random valid gaps, mid-load reset and ignored restarts.
// Build with LOAD_DATA_BITREV_IN_EN defined to check the bit-reversed placement.
module tb_load_data;

  localparam int N = 32;
  localparam int R = 5;
  localparam int D = 32;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_LD_en = 1'b0;
  logic         i_rx_valid = 1'b0;
  logic [D-1:0] i_rx_data = '0;
  logic         o_load_done, o_busy, o_rx_ready;
  logic         o_m0_w_en, o_m1_w_en;
  logic [R-2:0] o_m0_addr, o_m1_addr;
  logic [D-1:0] o_m0_wdata, o_m1_wdata;

  load_data #(.N(N), .R(R), .D(D)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_LD_en     (i_LD_en),
    .o_load_done (o_load_done),
    .o_busy      (o_busy),
    .i_rx_valid  (i_rx_valid),
    .i_rx_data   (i_rx_data),
    .o_rx_ready  (o_rx_ready),
    .o_m0_w_en   (o_m0_w_en),
    .o_m0_addr   (o_m0_addr),
    .o_m0_wdata  (o_m0_wdata),
    .o_m1_w_en   (o_m1_w_en),
    .o_m1_addr   (o_m1_addr),
    .o_m1_wdata  (o_m1_wdata)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state (0 idle, 1 load, 2 flush, 3 done)
  int         m_ps = 0;
  int         m_cnt = 0;
  bit         m_ready = 0;
  bit         e_we0, e_we1, e_done, e_busy;
  logic [3:0] e_addr0, e_addr1;
  logic [31:0] e_data0, e_data1;
  int         wr_n = 0;
  int         cyc = 0;
  int         last_acc = 0;
  int         cnt0, cnt1, dcnt;

  function automatic logic [4:0] exp_idx(input int n);
    logic [4:0] v;
    logic [4:0] r;
    v = n[4:0];
`ifdef LOAD_DATA_BITREV_IN_EN
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
`else
    r = v;
`endif
    return r;
  endfunction

  // Hand-computed placements: {known, bank, addr}
  function automatic logic [5:0] hand_ref(input int n);
`ifdef LOAD_DATA_BITREV_IN_EN
    case (n)
      0:       return {1'b1, 1'b0, 4'd0};
      1:       return {1'b1, 1'b1, 4'd0};
      2:       return {1'b1, 1'b1, 4'd8};
      3:       return {1'b1, 1'b0, 4'd8};
      default: return 6'd0;
    endcase
`else
    case (n)
      0:       return {1'b1, 1'b0, 4'd0};
      1:       return {1'b1, 1'b1, 4'd1};
      3:       return {1'b1, 1'b0, 4'd3};
      16:      return {1'b1, 1'b1, 4'd0};
      31:      return {1'b1, 1'b1, 4'd15};
      default: return 6'd0;
    endcase
`endif
  endfunction

  task automatic step(input logic valid, input logic ld, input logic rst);
    logic [4:0] idx;
    logic [5:0] h;
    i_rx_valid = valid;
    i_LD_en    = ld;
    i_rst      = rst;
    i_rx_data  = 32'h100 + 32'(m_cnt);
    @(posedge i_clk);
    cyc++;
    if (rst) begin
      m_ps = 0; m_cnt = 0; m_ready = 0;
      e_we0 = 0; e_we1 = 0; e_addr0 = '0; e_addr1 = '0;
      e_data0 = '0; e_data1 = '0; e_done = 0;
    end else begin
      e_we0 = 0; e_we1 = 0; e_done = 0;
      case (m_ps)
        0: if (ld) begin m_ps = 1; m_ready = 1; m_cnt = 0; end
        1: if (valid && m_ready) begin
          idx  = exp_idx(m_cnt);
          wr_n = m_cnt;
          if (^idx) begin
            e_we1 = 1; e_addr1 = idx[3:0]; e_data1 = 32'h100 + 32'(m_cnt);
          end else begin
            e_we0 = 1; e_addr0 = idx[3:0]; e_data0 = 32'h100 + 32'(m_cnt);
          end
          if (m_cnt == N - 1) begin
            m_ready = 0; m_ps = 2; m_cnt = 0; last_acc = cyc;
          end else begin
            m_cnt++;
          end
        end
        2: begin e_done = 1; m_ps = 3; end
        default: m_ps = 0;
      endcase
    end
    e_busy = (m_ps != 0);
    @(negedge i_clk);
    check_eq("rx_ready", o_rx_ready, m_ready);
    check_eq("busy", o_busy, e_busy);
    check_eq("load_done", o_load_done, e_done);
    check_eq("w_en", {o_m0_w_en, o_m1_w_en}, {e_we0, e_we1});
    check_eq("one_wen", o_m0_w_en & o_m1_w_en, 0);
    check_eq("m0_addr", o_m0_addr, e_addr0);
    check_eq("m1_addr", o_m1_addr, e_addr1);
    check_eq("m0_wdata", o_m0_wdata, e_data0);
    check_eq("m1_wdata", o_m1_wdata, e_data1);
    if (o_m0_w_en) cnt0++;
    if (o_m1_w_en) cnt1++;
    if (o_load_done) begin
      dcnt++;
      // done is high in the 2nd cycle after the last accept edge
      check_eq("done_latency", cyc - last_acc + 1, 2);
    end
    if (e_we0 || e_we1) begin
      h = hand_ref(wr_n);
      if (h[5]) begin
        check_eq("map_bank", o_m1_w_en, h[4]);
        check_eq("map_addr", h[4] ? o_m1_addr : o_m0_addr, h[3:0]);
      end
    end
  endtask

  task automatic full_stream(input string tag, input bit gaps, input int ld_at);
    bit done;
    cnt0 = 0; cnt1 = 0; dcnt = 0; done = 0;
    step(0, 1, 0);
    for (int i = 0; i < 400 && !done; i++) begin
      step(gaps ? 1'($urandom_range(0, 1)) : 1'b1, (i == ld_at), 0);
      if (m_ps == 0) done = 1;
    end
    check_eq({tag, "_complete"}, done, 1);
    // valid still high while idle: nothing may be written
    repeat (3) step(1, 0, 0);
    check_eq({tag, "_bank0_writes"}, cnt0, 16);
    check_eq({tag, "_bank1_writes"}, cnt1, 16);
    check_eq({tag, "_done_pulses"}, dcnt, 1);
  endtask

  initial begin
    @(negedge i_clk);
    step(0, 0, 1);
    step(0, 0, 1);
    check_eq("reset_busy", o_busy, 0);
    check_eq("reset_ready", o_rx_ready, 0);
    step(0, 0, 0);

    full_stream("plain", 0, -1);
    full_stream("gaps", 1, 20);

    // Reset after ten accepted samples, then restart from n=0
    step(0, 1, 0);
    for (int i = 0; i < 50 && m_cnt < 10; i++) step(1, 0, 0);
    check_eq("pre_reset_count", m_cnt, 10);
    step(1, 0, 1);
    check_eq("rst_wen", {o_m0_w_en, o_m1_w_en}, 0);
    check_eq("rst_busy", o_busy, 0);
    step(0, 0, 0);
    full_stream("restart", 0, 5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_data.md
Name: load_data

Overview:
- Input-side loader for the in-place FFT; the write-direction counterpart of the bit-reversed output reader.
- Accepts N complex samples over a valid/ready stream and writes each one into memory bank0 or bank1.
- Bank is the parity of the sample index; address is the low R-1 index bits. This is the placement the output reader expects.
- Started by the FFT controller; reports completion back to it with a one-cycle pulse.

Parameters:
- N, 32, FFT length in samples (power of two).
- R, 5, log2(N); index width.
- D, 32, sample width (real/imag packed), matching the memory bank data width.

Ports:
- i_clk  input  1  system clock; single clock domain.
- i_rst  input  1  synchronous, active-high reset.
- i_LD_en  input  1  controller start request; sampled only in ST_IDLE.
- o_load_done  output  1  one-cycle pulse after the last bank write.
- o_busy  output  1  high in every state except ST_IDLE.
- i_rx_valid  input  1  upstream sample valid.
- i_rx_data  input  D  upstream sample.
- o_rx_ready  output  1  loader can accept a sample (registered).
- o_m0_w_en  output  1  bank0 write enable.
- o_m0_addr  output  R-1  bank0 address.
- o_m0_wdata  output  D  bank0 write data.
- o_m1_w_en  output  1  bank1 write enable.
- o_m1_addr  output  R-1  bank1 address.
- o_m1_wdata  output  D  bank1 write data.

Behaviour:
- All outputs are registered.
- Reset values: all outputs 0; r_ps = ST_IDLE; r_cnt (R bits) = 0.
- States: ST_IDLE, ST_LOAD, ST_FLUSH, ST_DONE.
- ST_IDLE:
  - If i_LD_en: go to ST_LOAD, set o_rx_ready<=1, r_cnt<=0.
  - Otherwise stay.
- ST_LOAD:
  - Accept = i_rx_valid & o_rx_ready.
  - On accept, idx = r_cnt (or its bit-reverse, see Optional Feature); bank = ^idx.
  - bank=1: o_m1_w_en<=1, o_m1_addr<=idx[R-2:0], o_m1_wdata<=i_rx_data, o_m0_w_en<=0.
  - bank=0: the same on bank0, with o_m1_w_en<=0.
  - Without accept: both w_en<=0; addr/wdata hold.
  - Latency from accept edge to write-enable-high cycle: 1 cycle.
  - At most one w_en is high in any cycle. Back-to-back accepts give one write per cycle.
  - r_cnt increments on each accept. On the accept with r_cnt==N-1: r_cnt<=0, o_rx_ready<=0, go to ST_FLUSH. No sample beyond N is accepted.
- ST_FLUSH: the last write is active this cycle. Next edge: both w_en<=0, o_load_done<=1, go to ST_DONE.
- ST_DONE: o_load_done<=0 at the next edge; go to ST_IDLE.
- o_busy is high in ST_LOAD, ST_FLUSH and ST_DONE.
- Boundary conditions:
  - i_LD_en outside ST_IDLE is ignored.
  - i_rx_valid while o_rx_ready=0 is not consumed; upstream must hold data.
  - i_rst mid-load returns all state and outputs to reset values the next edge, with no further writes.
  - Partially loaded bank contents are undefined after a mid-load reset.
  - i_rx_valid gaps stall the load indefinitely without timeout.

Optional Feature:
- Macro: LOAD_DATA_BITREV_IN_EN.
- Defined: idx = bitReverse(r_cnt) (R bits), before the bank/address split. Input arrives in natural order and is stored in bit-reversed placement, for a decimation-in-time core.
- Undefined: idx = r_cnt, natural placement.
- Handshake, latency and state machine are identical in both builds.

Test Plan:
- N=32, R=5, no macro. Reset, pulse i_LD_en, stream 32 samples with data=0x100+n and valid held high. Required writes:
  - n=0: bank0 addr0.
  - n=1: bank1 addr1.
  - n=3: bank0 addr3.
  - n=16: bank1 addr0.
  - n=31: bank1 addr15.
  - Each write 1 cycle after its accept.
  - o_load_done pulses once, 2 cycles after the n=31 accept edge.
  - Exactly 16 writes per bank.
- Random i_rx_valid gaps (50% duty): same bank/address/data map as above; no w_en while idle; at most one w_en high per cycle.
- Valid held high after the 32nd sample: o_rx_ready=0 from the next cycle; no 33rd write; o_busy falls after o_load_done.
- Assert i_rst after sample 10: all outputs 0 the next cycle. A new i_LD_en restarts at n=0 (bank0 addr0).
- i_LD_en pulsed during ST_LOAD: no restart; count continues to 32.
- LOAD_DATA_BITREV_IN_EN defined:
  - n=1 -> idx 16 -> bank1 addr0.
  - n=2 -> idx 8 -> bank1 addr8.
  - n=3 -> idx 24 -> bank0 addr8.
  - Completion timing identical to the natural-order build.
